// File: rtl/spi_pkg.sv
// Shared types and sizing constants for the SPI master shift engine.
package spi_pkg;

  localparam int SPI_DATA_W = 8;
  localparam int SPI_DIV_W  = 8;

  typedef enum logic [1:0] {
    SPI_IDLE,
    SPI_SHIFT,
    SPI_DONE
  } spi_master_state_t;

  // Width of a counter that must hold 0..2*data_w (SCK edges per frame).
  function automatic int spi_edge_w(input int data_w);
    return $clog2(2 * data_w + 1);
  endfunction

endpackage

// File: rtl/spi_master_if.sv
// Register-file and pin side signals of the SPI master.
// lsb_first exists only when SPI_LSB_FIRST_EN is defined.
interface spi_master_if
  import spi_pkg::*;
#(
  parameter int DATA_W = SPI_DATA_W,
  parameter int DIV_W  = SPI_DIV_W
);

  logic              cpol;
  logic              cpha;
  logic [DIV_W-1:0]  clk_div;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              busy;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              sck;
  logic              mosi;
  logic              miso;
`ifdef SPI_LSB_FIRST_EN
  logic              lsb_first;

  modport master (
    input  cpol, cpha, clk_div, tx_data, tx_valid, miso, lsb_first,
    output busy, rx_data, rx_valid, sck, mosi
  );

  modport slave (
    output cpol, cpha, clk_div, tx_data, tx_valid, miso, lsb_first,
    input  busy, rx_data, rx_valid, sck, mosi
  );
`else
  modport master (
    input  cpol, cpha, clk_div, tx_data, tx_valid, miso,
    output busy, rx_data, rx_valid, sck, mosi
  );

  modport slave (
    output cpol, cpha, clk_div, tx_data, tx_valid, miso,
    input  busy, rx_data, rx_valid, sck, mosi
  );
`endif

endinterface

// File: rtl/spi_clk_gen.sv
// SCK generator: half-period counter, SCK register and edge counter.
// Strobes mark the clock edge on which an SCK edge is produced.
module spi_clk_gen
  import spi_pkg::*;
#(
  parameter int DATA_W = SPI_DATA_W,
  parameter int DIV_W  = SPI_DIV_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             run,
  input  logic             idle,
  input  logic             cpol,
  input  logic [DIV_W-1:0] clk_div,
  output logic             sck,
  output logic             lead_stb,
  output logic             trail_stb,
  output logic             last_edge
);

  localparam int EDGE_W = spi_edge_w(DATA_W);
  localparam logic [EDGE_W-1:0] LAST_IDX = EDGE_W'(2 * DATA_W - 1);

  logic [DIV_W-1:0]  div_reg;
  logic [DIV_W-1:0]  cnt_reg;
  logic [EDGE_W-1:0] edge_reg;
  logic              sck_reg;
  logic              edge_now;

  assign edge_now = run && (cnt_reg == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_reg  <= '0;
      cnt_reg  <= '0;
      edge_reg <= '0;
      sck_reg  <= 1'b0;
    end else if (start) begin
      div_reg  <= clk_div;
      cnt_reg  <= clk_div;
      edge_reg <= '0;
      sck_reg  <= cpol;
    end else if (run) begin
      if (cnt_reg == '0) begin
        sck_reg  <= ~sck_reg;
        edge_reg <= edge_reg + EDGE_W'(1);
        cnt_reg  <= div_reg;
      end else begin
        cnt_reg <= cnt_reg - DIV_W'(1);
      end
    end else if (idle) begin
      sck_reg <= cpol;
    end
  end

  // edge_reg still holds n-1 here, so an even value means odd (leading) edge n.
  assign lead_stb  = edge_now && !edge_reg[0];
  assign trail_stb = edge_now &&  edge_reg[0];
  assign last_edge = edge_now && (edge_reg == LAST_IDX);
  assign sck       = sck_reg;

endmodule

// File: rtl/spi_master.sv
// SPI master shift engine: FSM plus tx/rx shift registers around spi_clk_gen.
// Optional macro SPI_LSB_FIRST_EN adds the lsb_first bit-order control.
module spi_master
  import spi_pkg::*;
#(
  parameter int DATA_W = SPI_DATA_W,
  parameter int DIV_W  = SPI_DIV_W
) (
  input logic          clk,
  input logic          rst_n,
  spi_master_if.master bus
);

  spi_master_state_t state_reg, state_next;

  logic              start, run, idle;
  logic              lead_stb, trail_stb, last_edge;
  logic              sample_stb, drive_stb;
  logic              lsb_in;
  logic              cpha_reg;
  logic              lsb_reg;
  logic              busy_reg;
  logic              mosi_reg;
  logic              rx_valid_reg;
  logic [DATA_W-1:0] tx_shift_reg;
  logic [DATA_W-1:0] rx_shift_reg;
  logic [DATA_W-1:0] rx_data_reg;
  logic              sck_w;

`ifdef SPI_LSB_FIRST_EN
  assign lsb_in = bus.lsb_first;
`else
  assign lsb_in = 1'b0;
`endif

  function automatic logic tx_head(input logic [DATA_W-1:0] v, input logic lsb);
    return lsb ? v[0] : v[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] tx_advance(input logic [DATA_W-1:0] v, input logic lsb);
    return lsb ? (v >> 1) : (v << 1);
  endfunction

  function automatic logic [DATA_W-1:0] rx_insert(input logic [DATA_W-1:0] v,
                                                   input logic b, input logic lsb);
    return lsb ? {b, v[DATA_W-1:1]} : {v[DATA_W-2:0], b};
  endfunction

  spi_clk_gen #(
    .DATA_W (DATA_W),
    .DIV_W  (DIV_W)
  ) u_clk_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .run       (run),
    .idle      (idle),
    .cpol      (bus.cpol),
    .clk_div   (bus.clk_div),
    .sck       (sck_w),
    .lead_stb  (lead_stb),
    .trail_stb (trail_stb),
    .last_edge (last_edge)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= SPI_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    start      = 1'b0;
    run        = 1'b0;
    idle       = 1'b0;
    case (state_reg)
      SPI_IDLE: begin
        idle = 1'b1;
        if (bus.tx_valid) begin
          start      = 1'b1;
          state_next = SPI_SHIFT;
        end
      end
      SPI_SHIFT: begin
        run = 1'b1;
        if (last_edge) state_next = SPI_DONE;
      end
      SPI_DONE: state_next = SPI_IDLE;
      default:  state_next = SPI_IDLE;
    endcase
  end

  // The final trailing edge returns SCK to idle and never launches a new bit.
  assign sample_stb = cpha_reg ? trail_stb : lead_stb;
  assign drive_stb  = cpha_reg ? lead_stb  : (trail_stb && !last_edge);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpha_reg     <= 1'b0;
      lsb_reg      <= 1'b0;
      busy_reg     <= 1'b0;
      mosi_reg     <= 1'b0;
      rx_valid_reg <= 1'b0;
      tx_shift_reg <= '0;
      rx_shift_reg <= '0;
      rx_data_reg  <= '0;
    end else begin
      rx_valid_reg <= 1'b0;
      case (state_reg)
        SPI_IDLE: begin
          mosi_reg <= 1'b0;
          if (start) begin
            cpha_reg     <= bus.cpha;
            lsb_reg      <= lsb_in;
            busy_reg     <= 1'b1;
            rx_shift_reg <= '0;
            // With cpha=0 the first bit must be on the line before the first edge.
            if (bus.cpha) begin
              tx_shift_reg <= bus.tx_data;
            end else begin
              mosi_reg     <= tx_head(bus.tx_data, lsb_in);
              tx_shift_reg <= tx_advance(bus.tx_data, lsb_in);
            end
          end
        end
        SPI_SHIFT: begin
          if (sample_stb) rx_shift_reg <= rx_insert(rx_shift_reg, bus.miso, lsb_reg);
          if (drive_stb) begin
            mosi_reg     <= tx_head(tx_shift_reg, lsb_reg);
            tx_shift_reg <= tx_advance(tx_shift_reg, lsb_reg);
          end
        end
        SPI_DONE: begin
          rx_data_reg  <= rx_shift_reg;
          rx_valid_reg <= 1'b1;
          busy_reg     <= 1'b0;
          mosi_reg     <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy     = busy_reg;
  assign bus.rx_data  = rx_data_reg;
  assign bus.rx_valid = rx_valid_reg;
  assign bus.sck      = sck_w;
  assign bus.mosi     = mosi_reg;

endmodule

// File: tb/tb_spi_master.sv
// Randomized bench for spi_master with a bit-level slave model and frame checks.
module tb_spi_master;
  import spi_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_master_if #(.DATA_W(8), .DIV_W(8)) bus ();

  spi_master #(.DATA_W(8), .DIV_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic loop_en    = 1'b0;
  logic miso_model = 1'b0;
  logic lsb_sel    = 1'b0;
  assign bus.miso = loop_en ? bus.mosi : miso_model;
`ifdef SPI_LSB_FIRST_EN
  assign bus.lsb_first = lsb_sel;
`endif

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Monitor / slave state for the frame in flight.
  bit         mon_on  = 0;
  bit         mon_pha = 0;
  bit         mon_lsb = 0;
  logic [7:0] mon_sl  = '0;
  int         k, last_tog, d_cur, busy_cnt, rv_cnt, mosi_n;
  logic [7:0] mosi_got;
  logic       sck_prev;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic slave_bit(input int idx);
    int i;
    i = (idx < 0) ? 0 : ((idx > 7) ? 7 : idx);
    return mon_lsb ? mon_sl[i] : mon_sl[7-i];
  endfunction

  // One clock; observe just after the edge, acting as the SPI slave.
  task automatic tick();
    bit sample;
    @(posedge clk);
    #1;
    cyc++;
    if (mon_on) begin
      if (bus.busy) busy_cnt++;
      if (bus.rx_valid) rv_cnt++;
      if (bus.sck !== sck_prev) begin
        k++;
        check("sck_half", cyc - last_tog, d_cur + 1);
        last_tog = cyc;
        sample = mon_pha ? (k % 2 == 0) : (k % 2 == 1);
        if (sample && mosi_n < 8) begin
          if (mon_lsb) mosi_got[mosi_n] = bus.mosi;
          else         mosi_got[7-mosi_n] = bus.mosi;
          mosi_n++;
        end
        miso_model = slave_bit(mon_pha ? (k - 1) / 2 : k / 2);
      end
    end
    sck_prev = bus.sck;
  endtask

  task automatic xfer(input logic [7:0] tx, input logic [7:0] sl, input bit pol, input bit pha,
                      input logic [7:0] div, input bit lsb, input bit loop,
                      input int inj_at, input int rst_edge, input int tail);
    int e0, guard, lat, rvq;
    bit seen;
    logic [7:0] exp_rx;
    mon_sl     = sl;
    mon_lsb    = lsb;
    mon_pha    = pha;
    d_cur      = int'(div);
    loop_en    = loop;
    mosi_n     = 0;
    mosi_got   = '0;
    miso_model = slave_bit(0);
    exp_rx     = loop ? tx : sl;
    lat        = 16 * (int'(div) + 1) + 1;
    bus.cpol = pol; bus.cpha = pha; bus.clk_div = div; bus.tx_data = tx; lsb_sel = lsb;
    bus.tx_valid = 1'b1;
    tick();
    bus.tx_valid = 1'b0;
    e0 = cyc; k = 0; last_tog = cyc; rv_cnt = 0;
    busy_cnt = bus.busy ? 1 : 0;
    sck_prev = bus.sck;
    mon_on   = 1;
    check("busy_start", bus.busy, 1'b1);
    check("sck_start", bus.sck, pol);
    // Live config is scrambled; the frame must use the values latched at start.
    bus.cpol = 1'($urandom); bus.cpha = 1'($urandom); bus.clk_div = 8'($urandom);
    bus.tx_data = 8'($urandom); lsb_sel = 1'($urandom);
    seen  = 0;
    guard = lat + 20;
    for (int i = 0; i < guard && !seen; i++) begin
      if (inj_at >= 0 && cyc == e0 + inj_at) begin
        bus.tx_data  = 8'h55;
        bus.tx_valid = 1'b1;
      end
      tick();
      bus.tx_valid = 1'b0;
      if (rst_edge > 0 && k == rst_edge) begin
        rst_n = 1'b0;
        #1;
        mon_on = 0;
        check("rst_busy", bus.busy, 1'b0);
        check("rst_rx_valid", bus.rx_valid, 1'b0);
        check("rst_rx_data", bus.rx_data, 8'h00);
        check("rst_sck", bus.sck, 1'b0);
        check("rst_mosi", bus.mosi, 1'b0);
        bus.cpol = 1'b0; bus.cpha = 1'b0; bus.clk_div = '0; bus.tx_data = '0; lsb_sel = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        rvq = 0;
        for (int j = 0; j < 40; j++) begin
          tick();
          if (bus.rx_valid) rvq++;
        end
        check("rst_no_rx_valid", rvq, 0);
        check("rst_idle_busy", bus.busy, 1'b0);
        return;
      end
      if (bus.rx_valid) seen = 1;
    end
    check("rx_valid_seen", seen, 1'b1);
    check("latency", cyc - e0, lat);
    check("busy_cycles", busy_cnt, lat);
    check("rx_data", bus.rx_data, exp_rx);
    check("mosi_byte", mosi_got, tx);
    check("sck_edges", k, 16);
    check("sck_end", bus.sck, pol);
    check("busy_end", bus.busy, 1'b0);
    bus.cpol = pol; bus.cpha = pha; bus.clk_div = div; bus.tx_data = tx; lsb_sel = lsb;
    for (int j = 0; j < tail; j++) tick();
    if (tail > 0) begin
      check("rx_valid_pulses", rv_cnt, 1);
      check("busy_after", bus.busy, 1'b0);
      check("rx_data_held", bus.rx_data, exp_rx);
    end
    $display("xfer tx=%02h slave=%02h cpol=%0d cpha=%0d div=%0d lsb=%0d -> rx=%02h lat=%0d",
             tx, sl, pol, pha, div, lsb, bus.rx_data, cyc - e0 - tail);
    mon_on = 0;
  endtask

  initial begin
    bus.cpol = 1'b0; bus.cpha = 1'b0; bus.clk_div = '0; bus.tx_data = '0; bus.tx_valid = 1'b0;
    rst_n = 1'b0;
    repeat (3) tick();
    check("reset_busy", bus.busy, 1'b0);
    check("reset_rx_data", bus.rx_data, 8'h00);
    check("reset_rx_valid", bus.rx_valid, 1'b0);
    check("reset_sck", bus.sck, 1'b0);
    check("reset_mosi", bus.mosi, 1'b0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Mode 0, fastest SCK.
    xfer(8'hA5, 8'h3C, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, -1, -1, 2);
    // Mode 3, divider 3.
    xfer(8'h81, 8'hFF, 1'b1, 1'b1, 8'd3, 1'b0, 1'b0, -1, -1, 2);
    // Request while busy is dropped.
    xfer(8'hAA, 8'($urandom), 1'b0, 1'b0, 8'd1, 1'b0, 1'b0, 5, -1, 6);
    // Reset at SCK edge 7, then a normal frame.
    xfer(8'hC3, 8'h5A, 1'b0, 1'b1, 8'd1, 1'b0, 1'b0, -1, 7, 0);
    xfer(8'h0F, 8'h96, 1'b0, 1'b0, 8'd1, 1'b0, 1'b0, -1, -1, 2);
    // Back-to-back at the largest divider.
    xfer(8'h3E, 8'hC7, 1'b1, 1'b0, 8'd255, 1'b0, 1'b0, -1, -1, 0);
    xfer(8'hD2, 8'h19, 1'b1, 1'b0, 8'd255, 1'b0, 1'b0, -1, -1, 2);
`ifdef SPI_LSB_FIRST_EN
    xfer(8'h01, 8'h00, 1'b0, 1'b0, 8'd0, 1'b1, 1'b1, -1, -1, 2);
    check("lsb_first_bit", mosi_got[0], 1'b1);
`endif

    for (int n = 0; n < 24; n++) begin
      bit lsb_r;
`ifdef SPI_LSB_FIRST_EN
      lsb_r = 1'($urandom);
`else
      lsb_r = 1'b0;
`endif
      xfer(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
           8'($urandom_range(0, 4)), lsb_r, 1'b0, -1, -1, (n % 3 == 0) ? 0 : 2);
    end

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
